// File: rtl/cfg_pkg.sv
// cfg_pkg: shared FSM states and counter sizing for the configuration chain loaders
package cfg_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LO, HI, EMIT, DONE} state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/cfg_chain_loader_clkgen.sv
// cfg_shift_clkgen: divided, registered, glitch-free chain shift clock with phase counter
module cfg_shift_clkgen #(
  parameter int DIV = 2
) (
  input  logic cfg_clk,
  input  logic cfg_rst_n,
  input  logic en,
  input  logic clr,
  output logic shift_clk,
  output logic phase_last
);
  logic [7:0] phase;
  assign phase_last = phase == 8'(DIV - 1);
  // count a half-period while enabled and toggle the clock when it completes; clr forces low
  always_ff @(posedge cfg_clk or negedge cfg_rst_n)
    if (!cfg_rst_n) begin
      phase     <= '0;
      shift_clk <= 1'b0;
    end else if (clr) begin
      phase     <= '0;
      shift_clk <= 1'b0;
    end else if (en) begin
      phase     <= phase_last ? '0 : phase + 8'd1;
      shift_clk <= phase_last ? ~shift_clk : shift_clk;
    end
endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serialises a bitstream onto the config chain and reads back the old contents
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 48,
  parameter int DIV       = 2
) (
  input  logic       cfg_clk,
  input  logic       cfg_rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       shift_clk,
  output logic       shift_i,
  input  logic       shift_o,
  output logic       busy,
  output logic       done
);
  localparam int CW = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_inc;
  logic [7:0] dbuf, rb;
  logic en, clr, phase_last, idle_like;
  assign cnt_inc   = cnt + 1'b1;
  assign idle_like = state == IDLE || state == DONE;
  assign s_ready   = state == FETCH;
  assign m_valid   = state == EMIT;
  assign m_data    = rb;
  assign busy      = !idle_like;
  assign done      = state == DONE;
  cfg_shift_clkgen #(.DIV(DIV)) u_clkgen (
    .cfg_clk   (cfg_clk),
    .cfg_rst_n (cfg_rst_n),
    .en        (en),
    .clr       (clr),
    .shift_clk (shift_clk),
    .phase_last(phase_last)
  );
  // state register
  always_ff @(posedge cfg_clk or negedge cfg_rst_n)
    if (!cfg_rst_n) state <= IDLE;
    else state <= state_n;
  // next state and clock-generator control; abort overrides everything
  always_comb begin
    state_n = state;
    en      = 1'b0;
    clr     = abort;
    if (abort) state_n = IDLE;
    else if (idle_like && start) state_n = FETCH;
    else if (state == FETCH && s_valid) state_n = LO;
    else if (state == LO || state == HI) begin
      en = 1'b1;
      if (phase_last)
        state_n = state == LO ? HI : (cnt_inc == LAST || 3'(cnt_inc) == 3'd0) ? EMIT : LO;
    end else if (state == EMIT && m_ready) state_n = cnt == LAST ? DONE : FETCH;
  end
  // bit counter, data byte, head bit and readback byte, all keyed off state transitions
  always_ff @(posedge cfg_clk or negedge cfg_rst_n)
    if (!cfg_rst_n) begin
      cnt     <= '0;
      dbuf    <= '0;
      rb      <= '0;
      shift_i <= 1'b0;
    end else begin
      if (idle_like && state_n == FETCH) begin
        cnt <= '0;
        rb  <= '0;
      end
      if (state == FETCH && state_n == LO) begin
        dbuf    <= s_data;
        shift_i <= s_data[0];
      end
      if (state == LO && state_n == HI) rb[3'(cnt)] <= shift_o;
      if (state == HI && (state_n == LO || state_n == EMIT)) cnt <= cnt_inc;
      if (state == HI && state_n == LO) shift_i <= dbuf[3'(cnt_inc)];
      if (state == EMIT && state_n == FETCH) rb <= '0;
    end
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: randomized scenario bench with a behavioural shift-chain model
module tb_cfg_chain_loader;
  localparam int P = 10;
  logic cfg_clk = 0, cfg_rst_n = 1, start = 0, abort = 0, s_valid = 0, m_ready = 0;
  logic [7:0] s_data = 0, m_data;
  logic s_ready, m_valid, shift_clk, shift_i, shift_o, busy, done;
  logic start8 = 0, s8_valid = 0, m8_ready = 0;
  logic [7:0] s8_data = 0, m8_data;
  logic s8_ready, m8_valid, shift_clk8, shift_i8, shift_o8, busy8, done8;
  int errors = 0, checks = 0;
  logic [11:0] chain = 0;
  logic [7:0] chain8 = 0;
  int edges = 0, edges8 = 0;
  time edge_t[$], edge8_t[$];
  logic [7:0] rb8q[$];

  always #(P/2) cfg_clk = ~cfg_clk;

  cfg_chain_loader #(.CHAIN_LEN(12), .DIV(2)) dut (
    .cfg_clk(cfg_clk), .cfg_rst_n(cfg_rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .shift_clk(shift_clk), .shift_i(shift_i), .shift_o(shift_o),
    .busy(busy), .done(done));

  cfg_chain_loader #(.CHAIN_LEN(8), .DIV(1)) dut8 (
    .cfg_clk(cfg_clk), .cfg_rst_n(cfg_rst_n), .start(start8), .abort(abort),
    .s_data(s8_data), .s_valid(s8_valid), .s_ready(s8_ready),
    .m_data(m8_data), .m_valid(m8_valid), .m_ready(m8_ready),
    .shift_clk(shift_clk8), .shift_i(shift_i8), .shift_o(shift_o8),
    .busy(busy8), .done(done8));

  // chain model: head enters at the top, tail is bit 0
  assign shift_o  = chain[0];
  assign shift_o8 = chain8[0];
  always @(posedge shift_clk) begin
    chain = {shift_i, chain[11:1]};
    edges++;
    edge_t.push_back($time);
  end
  always @(posedge shift_clk8) begin
    chain8 = {shift_i8, chain8[7:1]};
    edges8++;
    edge8_t.push_back($time);
  end
  always @(negedge cfg_clk) if (m8_valid && m8_ready) rb8q.push_back(m8_data);

  task automatic pulse_start();
    @(negedge cfg_clk) start = 1;
    @(negedge cfg_clk) start = 0;
  endtask

  task automatic test_reset();
    #2 cfg_rst_n = 0;
    #1;
    checks++;
    if ({shift_clk, shift_i, s_ready, m_valid, busy, done, m_data} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got clk=%b i=%b rdy=%b mv=%b busy=%b done=%b md=%h expected all 0",
               shift_clk, shift_i, s_ready, m_valid, busy, done, m_data);
    end
    repeat (2) @(negedge cfg_clk);
    cfg_rst_n = 1;
    repeat (3) @(negedge cfg_clk);
    checks++;
    if ({busy, done, shift_clk, busy8, done8} !== 5'd0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b clk=%b busy8=%b done8=%b expected 0", busy, done, shift_clk, busy8, done8);
    end
  endtask

  task automatic run_load(input logic [11:0] pre, input logic [7:0] b0, input logic [7:0] b1,
                          input int s_stall, input int m_stall, input string tag);
    logic [7:0] got[2];
    logic [7:0] expb[2];
    logic [11:0] exp_chain;
    int n, bad;
    chain = pre;
    edges = 0;
    edge_t.delete();
    expb[0] = pre[7:0];
    expb[1] = {4'b0, pre[11:8]};
    exp_chain = {b1[3:0], b0};
    got[0] = 0;
    got[1] = 0;
    pulse_start();
    fork
      begin
        logic [7:0] bs[2];
        bs[0] = b0;
        bs[1] = b1;
        for (int i = 0; i < 2; i++) begin
          int nf, e0, sbad;
          nf = 0;
          while (!s_ready && nf < 500) begin @(negedge cfg_clk); nf++; end
          checks++;
          if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s fetch%0d_timeout s_ready=%b expected 1", tag, i, s_ready);
          end
          if (i == 1 && s_stall > 0) begin
            e0 = edges;
            sbad = 0;
            repeat (s_stall) begin @(negedge cfg_clk); if (shift_clk !== 1'b0) sbad++; end
            checks++;
            if (sbad != 0 || edges != e0) begin
              errors++;
              $display("FAIL %s s_stall high_samples=%0d edges=%0d expected 0 and %0d", tag, sbad, edges, e0);
            end
          end
          s_data = bs[i];
          s_valid = 1;
          @(posedge cfg_clk) #1;
          s_valid = 0;
          s_data = 8'($urandom);
        end
      end
      begin
        for (int j = 0; j < 2; j++) begin
          int nm, e0, mbad;
          nm = 0;
          while (!m_valid && nm < 800) begin @(negedge cfg_clk); nm++; end
          checks++;
          if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s emit%0d_timeout m_valid=%b expected 1", tag, j, m_valid);
          end
          if (j == 0 && m_stall > 0) begin
            e0 = edges;
            mbad = 0;
            repeat (m_stall) begin
              @(negedge cfg_clk);
              if (m_valid !== 1'b1 || m_data !== expb[0] || shift_clk !== 1'b0) mbad++;
            end
            checks++;
            if (mbad != 0 || edges != e0) begin
              errors++;
              $display("FAIL %s m_stall bad_samples=%0d edges=%0d m_data=%h expected 0, %0d, %h", tag, mbad, edges, m_data, e0, expb[0]);
            end
          end
          got[j] = m_data;
          m_ready = 1;
          @(posedge cfg_clk) #1;
          m_ready = 0;
        end
      end
    join
    n = 0;
    while (!done && n < 500) begin @(negedge cfg_clk); n++; end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done got done=%b busy=%b expected 1 0", tag, done, busy);
    end
    checks++;
    if (edges != 12) begin
      errors++;
      $display("FAIL %s edge_count got %0d expected 12", tag, edges);
    end
    checks++;
    if (chain !== exp_chain) begin
      errors++;
      $display("FAIL %s chain got %h expected %h", tag, chain, exp_chain);
    end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (got[j] !== expb[j]) begin
        errors++;
        $display("FAIL %s readback%0d got %h expected %h", tag, j, got[j], expb[j]);
      end
    end
    bad = 0;
    for (int k = 1; k < edge_t.size(); k++)
      if (k % 8 != 0 && edge_t[k] - edge_t[k-1] != 4 * P) bad++;
    checks++;
    if (bad != 0 || edge_t.size() < 12) begin
      errors++;
      $display("FAIL %s edge_spacing bad=%0d edges=%0d expected 0 and 12", tag, bad, edge_t.size());
    end
  endtask

  task automatic test_basic();
    run_load(12'hABC, 8'h5A, 8'h03, 0, 0, "basic");
  endtask

  task automatic test_s_stall();
    run_load(12'hABC, 8'h5A, 8'h03, 20, 0, "s_stall");
  endtask

  task automatic test_m_stall();
    run_load(12'hABC, 8'h5A, 8'h03, 0, 10, "m_stall");
  endtask

  task automatic test_random();
    repeat (4)
      run_load(12'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), "rand");
  endtask

  task automatic test_abort();
    int n, e_hold;
    chain = 12'($urandom);
    edges = 0;
    pulse_start();
    s_data = 8'($urandom);
    s_valid = 1;
    m_ready = 1;
    n = 0;
    while (!(edges == 6 && shift_clk) && n < 300) begin @(negedge cfg_clk); n++; end
    checks++;
    if (!(edges == 6 && shift_clk === 1'b1)) begin
      errors++;
      $display("FAIL abort reach_bit5 edges=%0d clk=%b expected 6 1", edges, shift_clk);
    end
    abort = 1;
    @(posedge cfg_clk) #1;
    abort = 0;
    s_valid = 0;
    m_ready = 0;
    checks++;
    if ({shift_clk, busy, done, s_ready, m_valid} !== 5'd0) begin
      errors++;
      $display("FAIL abort next_cycle clk=%b busy=%b done=%b rdy=%b mv=%b expected all 0",
               shift_clk, busy, done, s_ready, m_valid);
    end
    e_hold = edges;
    repeat (20) @(negedge cfg_clk);
    checks++;
    if (edges != 6 || e_hold != 6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort edge_total got %0d busy=%b expected 6 0", edges, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    chain = 12'($urandom);
    edges = 0;
    pulse_start();
    s_data = 8'($urandom);
    s_valid = 1;
    m_ready = 1;
    n = 0;
    while (!(edges == 9 && !shift_clk) && n < 400) begin @(negedge cfg_clk); n++; end
    checks++;
    if (!(edges == 9 && shift_clk === 1'b0 && busy === 1'b1)) begin
      errors++;
      $display("FAIL reset_mid reach_bit9 edges=%0d clk=%b busy=%b expected 9 0 1", edges, shift_clk, busy);
    end
    #1 cfg_rst_n = 0;
    #1;
    checks++;
    if ({shift_clk, shift_i, s_ready, m_valid, busy, done, m_data} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid outputs clk=%b i=%b rdy=%b mv=%b busy=%b done=%b md=%h expected all 0",
               shift_clk, shift_i, s_ready, m_valid, busy, done, m_data);
    end
    s_valid = 0;
    m_ready = 0;
    @(negedge cfg_clk) cfg_rst_n = 1;
    checks++;
    if (edges != 9) begin
      errors++;
      $display("FAIL reset_mid edges_after_reset got %0d expected 9", edges);
    end
    run_load(12'($urandom), 8'($urandom), 8'($urandom), 0, 0, "post_reset");
  endtask

  task automatic test_div1();
    logic [7:0] pre;
    int n, bad;
    pre = 8'($urandom);
    chain8 = pre;
    edges8 = 0;
    edge8_t.delete();
    rb8q.delete();
    s8_data = 8'hFF;
    s8_valid = 1;
    m8_ready = 1;
    @(negedge cfg_clk) start8 = 1;
    @(negedge cfg_clk) start8 = 0;
    n = 0;
    while (edges8 < 3 && n < 100) begin @(negedge cfg_clk); n++; end
    start8 = 1;
    @(negedge cfg_clk) start8 = 0;
    n = 0;
    while (!done8 && n < 200) begin @(negedge cfg_clk); n++; end
    repeat (12) @(negedge cfg_clk);
    s8_valid = 0;
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL div1 done got done=%b busy=%b expected 1 0", done8, busy8);
    end
    checks++;
    if (edges8 != 8) begin
      errors++;
      $display("FAIL div1 edge_count got %0d expected 8", edges8);
    end
    checks++;
    if (chain8 !== 8'hFF) begin
      errors++;
      $display("FAIL div1 chain got %h expected ff", chain8);
    end
    checks++;
    if (rb8q.size() != 1 || rb8q[0] !== pre) begin
      errors++;
      $display("FAIL div1 readback count=%0d first=%h expected 1 %h", rb8q.size(), rb8q.size() > 0 ? rb8q[0] : 8'h00, pre);
    end
    bad = 0;
    for (int k = 1; k < edge8_t.size(); k++) if (edge8_t[k] - edge8_t[k-1] != 2 * P) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL div1 edge_spacing bad=%0d expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_s_stall();
    test_m_stall();
    test_random();
    test_abort();
    test_reset_mid();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(P * 40000);
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
